// File: rtl/audio_fifo_param.sv
// Parametrised single-clock first-word-fall-through sample FIFO over synchronous RAM,
// with almost-full, hysteretic primed start flag, sticky error flags and flush.
module audio_fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int PRIME_LVL = 512,
    parameter int AF_MARGIN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              primed,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_AF    = (ADDR_W+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_W:0]   LVL_PRIME = (ADDR_W+1)'(PRIME_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_almost_full;
    logic              r_primed;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_ready;
    logic              w_wr_acc;
    logic              w_ov_ev;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_uf_ev;
    logic              w_rd_valid_nxt;
    logic              w_primed_nxt;
    logic [ADDR_W:0]   w_mem_cnt_nxt;
    logic [ADDR_W:0]   w_level_nxt;

    // Handshake decode; flush masks the write and the prefetch so neither lands.
    always_comb begin
        w_wr_ready = (r_level < LVL_FULL);
        w_wr_acc   = wr_valid & w_wr_ready & ~flush;
        w_ov_ev    = wr_valid & ~w_wr_ready & ~flush;
        w_rd_en    = (r_mem_cnt != '0) & (~r_rd_valid | rd_ready) & ~flush;
        w_pop      = r_rd_valid & rd_ready;
        w_uf_ev    = rd_ready & ~r_rd_valid & r_primed;
    end

    always_comb begin
        w_mem_cnt_nxt = r_mem_cnt;
        if (flush) begin
            w_mem_cnt_nxt = '0;
        end else if (w_wr_acc && !w_rd_en) begin
            w_mem_cnt_nxt = r_mem_cnt + CNT_ONE;
        end else if (!w_wr_acc && w_rd_en) begin
            w_mem_cnt_nxt = r_mem_cnt - CNT_ONE;
        end

        w_rd_valid_nxt = r_rd_valid;
        if (flush) begin
            w_rd_valid_nxt = 1'b0;
        end else if (w_rd_en) begin
            w_rd_valid_nxt = 1'b1;
        end else if (w_pop) begin
            w_rd_valid_nxt = 1'b0;
        end

        w_level_nxt = w_mem_cnt_nxt + {{ADDR_W{1'b0}}, w_rd_valid_nxt};

        // Primed holds while draining; only underflow or flush drop it.
        w_primed_nxt = r_primed;
        if (flush || w_uf_ev) begin
            w_primed_nxt = 1'b0;
        end else if (w_level_nxt > LVL_PRIME) begin
            w_primed_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_cnt     <= '0;
            r_level       <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_almost_full <= 1'b0;
            r_primed      <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_rd_en) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end
            if (w_rd_en) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_mem_cnt     <= w_mem_cnt_nxt;
            r_rd_valid    <= w_rd_valid_nxt;
            r_level       <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= LVL_AF);
            r_primed      <= w_primed_nxt;
            // A fresh error event wins over err_clr in the same cycle.
            r_overflow    <= w_ov_ev | (r_overflow & ~err_clr);
            r_underflow   <= w_uf_ev | (r_underflow & ~err_clr);
        end
    end

    assign wr_ready    = w_wr_ready;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign level       = r_level;
    assign almost_full = r_almost_full;
    assign primed      = r_primed;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_audio_fifo_param.sv
// Self-checking bench for audio_fifo_param: directed scenarios plus randomized
// traffic against a queue-based reference model of the FIFO behaviour.
module tb_audio_fifo_param;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int PRIME_LVL = 512;
    localparam int AF_MARGIN = 16;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              err_clr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   level;
    logic              almost_full;
    logic              primed;
    logic              overflow;
    logic              underflow;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: the queue holds every word in the FIFO; a word becomes
    // visible on rd_data one cycle after it is written.
    logic [DATA_W-1:0] m_q[$];
    bit                m_rv;
    bit                m_primed;
    bit                m_ov;
    bit                m_uf;
    logic [DATA_W-1:0] m_rd_data;

    audio_fifo_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PRIME_LVL(PRIME_LVL),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .err_clr    (err_clr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .level      (level),
        .almost_full(almost_full),
        .primed     (primed),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_q.delete();
        m_rv      = 0;
        m_primed  = 0;
        m_ov      = 0;
        m_uf      = 0;
        m_rd_data = '0;
    endtask

    task automatic model_step();
        bit pop, uf_ev, full, wr_acc, ov_ev;
        int remaining;
        pop    = m_rv && rd_ready;
        uf_ev  = rd_ready && !m_rv && m_primed;
        full   = (m_q.size() == DEPTH);
        wr_acc = wr_valid && !full && !flush;
        ov_ev  = wr_valid && full && !flush;
        m_ov   = ov_ev || (m_ov && !err_clr);
        m_uf   = uf_ev || (m_uf && !err_clr);
        if (flush) begin
            m_q.delete();
            m_rv     = 0;
            m_primed = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            remaining = m_q.size();
            if (wr_acc) m_q.push_back(wr_data);
            m_rv = (remaining > 0);
            if (m_rv) m_rd_data = m_q[0];
            if (uf_ev) m_primed = 0;
            else if (m_q.size() > PRIME_LVL) m_primed = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wr_valid = 0;
        rd_ready = 0;
        flush    = 0;
        err_clr  = 0;
        wr_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); else n_pass++;
        n_total++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %0h expected 0", rd_data); else n_pass++;
        n_total++; if (level !== '0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
        n_total++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %0b expected 0", almost_full); else n_pass++;
        n_total++; if (primed !== 1'b0) $display("FAIL reset_primed: got %0b expected 0", primed); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %0b expected 0", underflow); else n_pass++;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'(i);
            tick();
            n_total++; if (int'(level) != i) $display("FAIL basic_fill_level: got %0d expected %0d", level, i); else n_pass++;
            if (i == 1) begin
                n_total++; if (rd_valid !== 1'b0) $display("FAIL basic_latency_early: got %0b expected 0", rd_valid); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0001) $display("FAIL basic_latency: got v=%0b d=%0h expected v=1 d=1", rd_valid, rd_data); else n_pass++;
            end
        end
        wr_valid = 0;
        rd_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            n_total++; if (rd_valid !== 1'b1 || int'(rd_data) != i) $display("FAIL basic_drain: got v=%0b d=%0h expected v=1 d=%0h", rd_valid, rd_data, i); else n_pass++;
            tick();
        end
        n_total++; if (level !== '0 || rd_valid !== 1'b0) $display("FAIL basic_empty: got level=%0d v=%0b expected 0 0", level, rd_valid); else n_pass++;
        tick();
        n_total++; if (underflow !== 1'b0) $display("FAIL basic_benign_read: got uf=%0b expected 0", underflow); else n_pass++;
        rd_ready = 0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'($urandom);
            tick();
            n_total++; if (int'(level) != m_q.size() || almost_full !== (m_q.size() >= DEPTH - AF_MARGIN)) $display("FAIL fill_level_af: got level=%0d af=%0b expected level=%0d", level, almost_full, m_q.size()); else n_pass++;
            n_total++; if (primed !== m_primed) $display("FAIL fill_primed: got %0b expected %0b", primed, m_primed); else n_pass++;
        end
        wr_data = 16'hDEAD;
        n_total++; if (wr_ready !== 1'b0 || almost_full !== 1'b1) $display("FAIL full_flags: got wr_ready=%0b af=%0b expected 0 1", wr_ready, almost_full); else n_pass++;
        tick();
        wr_valid = 0;
        n_total++; if (overflow !== 1'b1) $display("FAIL overflow_set: got %0b expected 1", overflow); else n_pass++;
        n_total++; if (int'(level) != DEPTH) $display("FAIL overflow_level: got %0d expected %0d", level, DEPTH); else n_pass++;
        n_total++; if (rd_data !== m_q[0] || m_q[DEPTH-1] === 16'hDEAD && m_q.size() != DEPTH) $display("FAIL overflow_head: got %0h expected %0h", rd_data, m_q[0]); else n_pass++;
        err_clr = 1;
        tick();
        err_clr = 0;
        n_total++; if (overflow !== 1'b0) $display("FAIL overflow_clr: got %0b expected 0", overflow); else n_pass++;
        flush    = 1;
        wr_valid = 1;
        tick();
        flush    = 0;
        wr_valid = 0;
        n_total++; if (overflow !== 1'b0 || level !== '0 || primed !== 1'b0 || rd_valid !== 1'b0) $display("FAIL flush_full: got ov=%0b level=%0d primed=%0b v=%0b expected 0 0 0 0", overflow, level, primed, rd_valid); else n_pass++;
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] nxt_wr;
        logic [DATA_W-1:0] exp_rd;
        nxt_wr = '0;
        exp_rd = '0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1;
            wr_data  = nxt_wr;
            nxt_wr++;
            tick();
        end
        wr_valid = 0;
        tick();
        wr_valid = 1;
        rd_ready = 1;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            wr_data = nxt_wr;
            n_total++; if (rd_valid !== 1'b1 || rd_data !== exp_rd) $display("FAIL stream_data: cycle %0d got v=%0b d=%0h expected v=1 d=%0h", c, rd_valid, rd_data, exp_rd); else n_pass++;
            tick();
            nxt_wr++;
            exp_rd++;
            n_total++; if (int'(level) != 8) $display("FAIL stream_level: cycle %0d got %0d expected 8", c, level); else n_pass++;
        end
        set_idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_primed();
        int guard;
        for (int i = 0; i <= PRIME_LVL; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'($urandom);
            tick();
            n_total++; if (primed !== (i == PRIME_LVL)) $display("FAIL primed_rise: after %0d writes got %0b expected %0b", i + 1, primed, i == PRIME_LVL); else n_pass++;
        end
        wr_valid = 0;
        rd_ready = 1;
        guard = 0;
        while (rd_valid && guard < DEPTH + 8) begin
            n_total++; if (rd_data !== m_q[0] || primed !== 1'b1) $display("FAIL primed_drain: got d=%0h primed=%0b expected d=%0h primed=1", rd_data, primed, m_q[0]); else n_pass++;
            tick();
            guard++;
        end
        n_total++; if (guard != PRIME_LVL + 1) $display("FAIL primed_drain_count: got %0d expected %0d", guard, PRIME_LVL + 1); else n_pass++;
        n_total++; if (underflow !== 1'b0 || primed !== 1'b1) $display("FAIL primed_hold_empty: got uf=%0b primed=%0b expected 0 1", underflow, primed); else n_pass++;
        tick();
        n_total++; if (underflow !== 1'b1 || primed !== 1'b0) $display("FAIL underflow_event: got uf=%0b primed=%0b expected 1 0", underflow, primed); else n_pass++;
        repeat (3) begin
            tick();
            n_total++; if (underflow !== 1'b1 || primed !== 1'b0 || overflow !== 1'b0) $display("FAIL underflow_stable: got uf=%0b primed=%0b ov=%0b expected 1 0 0", underflow, primed, overflow); else n_pass++;
        end
        rd_ready = 0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'($urandom);
            tick();
        end
        wr_valid = 0;
        tick();
        n_total++; if (int'(level) != 7) $display("FAIL flush_pre_level: got %0d expected 7", level); else n_pass++;
        flush    = 1;
        wr_valid = 1;
        wr_data  = DATA_W'($urandom);
        tick();
        flush    = 0;
        wr_valid = 0;
        n_total++; if (level !== '0 || rd_valid !== 1'b0 || primed !== 1'b0) $display("FAIL flush_clear: got level=%0d v=%0b primed=%0b expected 0 0 0", level, rd_valid, primed); else n_pass++;
        n_total++; if (overflow !== 1'b0 || underflow !== 1'b1) $display("FAIL flush_sticky: got ov=%0b uf=%0b expected 0 1", overflow, underflow); else n_pass++;
        tick();
        n_total++; if (level !== '0 || rd_valid !== 1'b0) $display("FAIL flush_write_dropped: got level=%0d v=%0b expected 0 0", level, rd_valid); else n_pass++;
    endtask

    task automatic test_err_clr();
        err_clr  = 1;
        rd_ready = 1;
        tick();
        err_clr = 0;
        n_total++; if (underflow !== 1'b0) $display("FAIL errclr_uf: got %0b expected 0", underflow); else n_pass++;
        repeat (3) begin
            tick();
            n_total++; if (underflow !== 1'b0 || overflow !== 1'b0) $display("FAIL errclr_benign: got uf=%0b ov=%0b expected 0 0", underflow, overflow); else n_pass++;
        end
        rd_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'($urandom);
            tick();
        end
        err_clr = 1;
        tick();
        n_total++; if (overflow !== 1'b1) $display("FAIL errclr_priority: got ov=%0b expected 1", overflow); else n_pass++;
        wr_valid = 0;
        tick();
        err_clr = 0;
        n_total++; if (overflow !== 1'b0) $display("FAIL errclr_after: got ov=%0b expected 0", overflow); else n_pass++;
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset_async();
        for (int i = 0; i < 300; i++) begin
            wr_valid = 1;
            wr_data  = DATA_W'($urandom);
            tick();
        end
        rd_ready = 1;
        for (int i = 0; i < 20; i++) begin
            wr_data = DATA_W'($urandom);
            tick();
            n_total++; if (int'(level) != 300) $display("FAIL rst_stream_level: got %0d expected 300", level); else n_pass++;
        end
        #3;
        rst = 1;
        #1;
        n_total++; if (rd_valid !== 1'b0 || level !== '0 || rd_data !== '0) $display("FAIL rst_async_data: got v=%0b level=%0d d=%0h expected 0 0 0", rd_valid, level, rd_data); else n_pass++;
        n_total++; if (primed !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || almost_full !== 1'b0) $display("FAIL rst_async_flags: got p=%0b ov=%0b uf=%0b af=%0b expected 0 0 0 0", primed, overflow, underflow, almost_full); else n_pass++;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %0b expected 1", wr_ready); else n_pass++;
        wr_valid = 1;
        wr_data  = 16'h1234;
        tick();
        wr_valid = 0;
        n_total++; if (int'(level) != 1 || rd_valid !== 1'b0) $display("FAIL rst_fresh_write: got level=%0d v=%0b expected 1 0", level, rd_valid); else n_pass++;
        tick();
        n_total++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) $display("FAIL rst_fresh_read: got v=%0b d=%0h expected 1 1234", rd_valid, rd_data); else n_pass++;
    endtask

    task automatic test_random();
        int pw[4] = '{90, 50, 10, 70};
        int pr[4] = '{20, 50, 90, 70};
        int len[4] = '{1500, 1000, 1000, 500};
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < len[b]; c++) begin
                wr_valid = ($urandom_range(99) < pw[b]);
                rd_ready = ($urandom_range(99) < pr[b]);
                flush    = ($urandom_range(399) == 0);
                err_clr  = ($urandom_range(59) == 0);
                wr_data  = DATA_W'($urandom);
                tick();
                n_total++; if (rd_valid !== m_rv || int'(level) != m_q.size() || wr_ready !== (m_q.size() < DEPTH)) $display("FAIL rand_state: blk %0d cyc %0d got v=%0b level=%0d rdy=%0b expected v=%0b level=%0d", b, c, rd_valid, level, wr_ready, m_rv, m_q.size()); else n_pass++;
                n_total++; if (m_rv && rd_data !== m_rd_data) $display("FAIL rand_data: blk %0d cyc %0d got %0h expected %0h", b, c, rd_data, m_rd_data); else n_pass++;
                n_total++; if (primed !== m_primed || overflow !== m_ov || underflow !== m_uf || almost_full !== (m_q.size() >= DEPTH - AF_MARGIN)) $display("FAIL rand_flags: blk %0d cyc %0d got p=%0b ov=%0b uf=%0b af=%0b expected p=%0b ov=%0b uf=%0b", b, c, primed, overflow, underflow, almost_full, m_primed, m_ov, m_uf); else n_pass++;
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stream();
        test_primed();
        test_flush();
        test_err_clr();
        test_reset_async();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
